// File: rtl/rr_mux_pkg.sv
// Shared types and grant helpers for the round-robin 4:1 mux arbiter.
//   NCH         : number of input channels (fixed at 4)
//   chan_idx_t  : 2-bit channel index
//   chan_mask_t : 4-bit per-channel request/grant mask
//   pick_t      : grant result {any, idx}
//   rr_pick     : round-robin pick starting after 'last'
//   fixed_pick  : lowest-index-wins pick (used when RR_MUX_FIXED_PRIO_EN is defined)
package rr_mux_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] chan_idx_t;
  typedef logic [3:0] chan_mask_t;

  typedef struct packed {
    logic      any;
    chan_idx_t idx;
  } pick_t;

  // Candidates are visited from lowest to highest priority so that the
  // final overwrite is the channel right after 'last'. With k=4 the 2-bit
  // add wraps back onto 'last' itself, which is the lowest priority.
  function automatic pick_t rr_pick(input chan_mask_t req, input chan_idx_t last);
    pick_t     res;
    chan_idx_t cand;
    res = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = last + chan_idx_t'(k);
      if (req[cand]) begin
        res.any = 1'b1;
        res.idx = cand;
      end
    end
    return res;
  endfunction

  function automatic pick_t fixed_pick(input chan_mask_t req);
    pick_t res;
    res = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[k]) begin
        res.any = 1'b1;
        res.idx = chan_idx_t'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux_4_1_arb_pick.sv
// rr_pick_4: combinational grant selection for four requesters.
//   req_i  : request mask (already qualified by the load condition)
//   last_i : index of the most recently granted channel
//   idx_o  : granted channel index (valid only when any_o=1)
//   any_o  : at least one request present
// Build option RR_MUX_FIXED_PRIO_EN switches to fixed priority (channel 0
// highest); last_i is then ignored.
import rr_mux_pkg::*;

module rr_pick_4 (
  input  chan_mask_t req_i,
  input  chan_idx_t  last_i,
  output chan_idx_t  idx_o,
  output logic       any_o
);

  pick_t pick;

`ifdef RR_MUX_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;
  assign pick        = fixed_pick(req_i);
`else
  assign pick        = rr_pick(req_i, last_i);
`endif

  assign idx_o = pick.idx;
  assign any_o = pick.any;

endmodule

// File: rtl/rr_mux_4_1_arb.sv
// rr_mux_4_1_arb: round-robin arbiter feeding a registered 4:1 data mux.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : per-channel request, bit i pairs with in_data<i>
//   in_data0-3 : channel data, W bits each
//   in_ready   : one-hot (or zero) transfer strobe per channel
//   out_valid  : out_data/sel hold a valid word
//   out_data   : registered data of the granted channel
//   sel        : registered index of the channel that produced out_data
//   out_ready  : downstream accepts the current word
// Build option RR_MUX_FIXED_PRIO_EN: fixed priority, no round-robin pointer.
import rr_mux_pkg::*;

module rr_mux_4_1_arb #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   sel,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  chan_idx_t    sel_q,       sel_d;
  chan_idx_t    last_cur;

  logic         load_en;
  chan_mask_t   req_masked;
  chan_idx_t    grant_idx;
  logic         grant_any;
  chan_mask_t   grant_mask;
  logic         transfer;
  logic [W-1:0] data_arr [NCH];
  logic [W-1:0] grant_data;

  // Load decision looks only at the output register, keeping in_valid off
  // any combinational path to out_ready.
  assign load_en    = !out_valid_q || out_ready;
  assign req_masked = load_en ? in_valid : '0;

  rr_pick_4 u_pick (
    .req_i  (req_masked),
    .last_i (last_cur),
    .idx_o  (grant_idx),
    .any_o  (grant_any)
  );

  // rst_n gates the strobes so no channel sees a handshake while in reset.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign grant_mask[gi] = rst_n && grant_any && (grant_idx == chan_idx_t'(gi));
  end

  assign in_ready = grant_mask;
  assign transfer = |grant_mask;

  assign data_arr[0] = in_data0;
  assign data_arr[1] = in_data1;
  assign data_arr[2] = in_data2;
  assign data_arr[3] = in_data3;
  assign grant_data  = data_arr[grant_idx];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      sel_d       = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign last_cur = chan_idx_t'(NCH - 1);
`else
  chan_idx_t last_q;

  // Pointer resets to 3 so channel 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= chan_idx_t'(NCH - 1);
    end else if (transfer) begin
      last_q <= grant_idx;
    end
  end

  assign last_cur = last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_rr_mux_4_1_arb.sv
module tb_rr_mux_4_1_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] din [4];
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] sel;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  // random-phase reference model
  logic       exp_ov;
  logic [3:0] exp_data;
  logic [1:0] exp_sel;
  logic [1:0] exp_last;
  logic [3:0] exp_ready;
  logic [3:0] vreg;
  int         wait_cnt [4];
  int         g;

  assign in_data0 = din[0];
  assign in_data1 = din[1];
  assign in_data2 = din[2];
  assign in_data3 = din[3];

  rr_mux_4_1_arb #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 4'h0;

    // reset state, with requests present: no strobes during reset
    #2;
    in_valid = 4'b1111;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_sel", {6'd0, sel}, 8'h00);
    chk("rst_out_data", {4'd0, out_data}, 8'h00);
    chk("rst_in_ready", {4'd0, in_ready}, 8'h00);
    $display("reset: out_valid=%0b sel=%0d in_ready=%b", out_valid, sel, in_ready);

    @(negedge clk);
    rst_n = 1'b1;
    din[0] = 4'h5; din[1] = 4'h6; din[2] = 4'h7; din[3] = 4'h8;
    out_ready = 1'b1;
    #1;
    chk("all_first_ready", {4'd0, in_ready}, 8'h01);
`ifdef RR_MUX_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fixed_all_sel", {6'd0, sel}, 8'h00);
      chk("fixed_all_data", {4'd0, out_data}, 8'h05);
      $display("fixed all: sel=%0d data=%0h", sel, out_data);
    end
`else
    // grant order from reset with all channels requesting: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      logic [3:0] onehot_next;
      step();
      onehot_next = 4'b0001 << ((k + 1) % 4);
      chk("rr_out_valid", {7'd0, out_valid}, 8'h01);
      chk("rr_sel", {6'd0, sel}, 8'(k % 4));
      chk("rr_data", {4'd0, out_data}, {4'd0, din[k % 4]});
      chk("rr_next_ready", {4'd0, in_ready}, {4'd0, onehot_next});
      $display("rr: sel=%0d data=%0h next in_ready=%b", sel, out_data, in_ready);
    end
`endif

    // reset mid-stream with a word held: cleared immediately, no clock
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("midrst_sel", {6'd0, sel}, 8'h00);
    chk("midrst_in_ready", {4'd0, in_ready}, 8'h00);
    $display("mid reset: out_valid=%0b sel=%0d in_ready=%b", out_valid, sel, in_ready);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // single requester
    in_valid = 4'b0100;
    din[2] = 4'hA;
    #1;
    chk("single_ready", {4'd0, in_ready}, 8'h04);
    step();
    chk("single_valid", {7'd0, out_valid}, 8'h01);
    chk("single_data", {4'd0, out_data}, 8'h0A);
    chk("single_sel", {6'd0, sel}, 8'h02);
    $display("single: sel=%0d data=%0h", sel, out_data);

    // backpressure: output held, no strobes
    out_ready = 1'b0;
    in_valid = 4'b0011;
    din[0] = 4'h3; din[1] = 4'hE;
    #1;
    chk("bp_ready", {4'd0, in_ready}, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", {7'd0, out_valid}, 8'h01);
      chk("bp_sel", {6'd0, sel}, 8'h02);
      chk("bp_data", {4'd0, out_data}, 8'h0A);
      chk("bp_ready_hold", {4'd0, in_ready}, 8'h00);
      $display("stall: sel=%0d data=%0h in_ready=%b", sel, out_data, in_ready);
    end
    // release: pending word consumed and replaced in the same cycle
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {4'd0, in_ready}, 8'h01);
    step();
    chk("bp_nobubble_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_nobubble_sel", {6'd0, sel}, 8'h00);
    chk("bp_nobubble_data", {4'd0, out_data}, 8'h03);
    $display("release: sel=%0d data=%0h", sel, out_data);

`ifdef RR_MUX_FIXED_PRIO_EN
    // fixed priority: channel 1 wins every time over 2 and 3
    in_valid = 4'b1110;
    din[1] = 4'h9; din[2] = 4'h4; din[3] = 4'hC;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fixed_sel", {6'd0, sel}, 8'h01);
      chk("fixed_data", {4'd0, out_data}, 8'h09);
      $display("fixed: sel=%0d data=%0h", sel, out_data);
    end
`else
    // wrap-around: move pointer to 3, then alternate 0 and 3
    in_valid = 4'b1000;
    din[3] = 4'hC;
    step();
    chk("wrap_sel3", {6'd0, sel}, 8'h03);
    in_valid = 4'b1001;
    din[0] = 4'h7;
    #1;
    chk("wrap_ready0", {4'd0, in_ready}, 8'h01);
    step();
    chk("wrap_sel0", {6'd0, sel}, 8'h00);
    chk("wrap_data0", {4'd0, out_data}, 8'h07);
    chk("wrap_ready3", {4'd0, in_ready}, 8'h08);
    step();
    chk("wrap_sel3b", {6'd0, sel}, 8'h03);
    chk("wrap_data3", {4'd0, out_data}, 8'h0C);
    step();
    chk("wrap_sel0b", {6'd0, sel}, 8'h00);
    $display("wrap: sel=%0d data=%0h", sel, out_data);
`endif

    // drain: no request, word consumed
    in_valid = 4'b0000;
    step();
    chk("drain_valid", {7'd0, out_valid}, 8'h00);
    $display("drain: out_valid=%0b", out_valid);

`ifndef RR_MUX_FIXED_PRIO_EN
    // random fairness + scoreboard against an independent model
    rst_n = 1'b0;
    in_valid = 4'b0000;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ov = 1'b0; exp_data = 4'h0; exp_sel = 2'd0; exp_last = 2'd3;
    vreg = 4'b0000;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      // a requester holds valid until granted; data may change meanwhile
      for (int i = 0; i < 4; i++) begin
        if (!vreg[i] && ($urandom_range(2) == 0)) begin
          vreg[i] = 1'b1;
          wait_cnt[i] = 0;
        end
        din[i] = 4'($urandom_range(15));
      end
      in_valid = vreg;
      out_ready = ($urandom_range(3) != 0);
      #1;
      g = -1;
      if (!exp_ov || out_ready) begin
        for (int k = 1; k <= 4; k++) begin
          int cand;
          cand = (int'(exp_last) + k) % 4;
          if (g < 0 && vreg[cand]) g = cand;
        end
      end
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rand_ready", {4'd0, in_ready}, {4'd0, exp_ready});
      step();
      if (g >= 0) begin
        exp_ov = 1'b1;
        exp_data = din[g];
        exp_sel = 2'(g);
        exp_last = 2'(g);
        for (int i = 0; i < 4; i++) begin
          if (i == g) wait_cnt[i] = 0;
          else if (vreg[i]) wait_cnt[i]++;
        end
        vreg[g] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (wait_cnt[i] > 3) chk("rand_fair", 8'(wait_cnt[i]), 8'd3);
        end
      end else if (exp_ov && out_ready) begin
        exp_ov = 1'b0;
      end
      chk("rand_valid", {7'd0, out_valid}, {7'd0, exp_ov});
      if (exp_ov) begin
        chk("rand_sel", {6'd0, sel}, {6'd0, exp_sel});
        chk("rand_data", {4'd0, out_data}, {4'd0, exp_data});
      end
      $display("rand %0d: in_valid=%b out_ready=%0b in_ready=%b out_valid=%0b sel=%0d data=%0h",
               c, in_valid, out_ready, exp_ready, out_valid, sel, out_data);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_4_1_arb.md
Name: rr_mux_4_1_arb

Overview:
- Round-robin arbiter that feeds a 4:1 data multiplexer stage: four 4-bit valid/ready input channels, one registered valid/ready output.
- Each cycle it picks one requesting channel and registers that channel's data.
- It exports the registered 2-bit channel index on `sel` so downstream mux/demux logic can track the word's origin.
- Sits directly upstream of the 4:1 mux datapath in the combinational-logic block set.

Parameters:
- W, 4, data width of each channel and of out_data.
- N is fixed at 4 channels and is not a parameter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-channel request; bit i belongs to in_data_i.
- in_data0  input  W  channel 0 data.
- in_data1  input  W  channel 1 data.
- in_data2  input  W  channel 2 data.
- in_data3  input  W  channel 3 data.
- in_ready  output  4  one-hot or zero; bit i high means channel i transfers this cycle.
- out_valid  output  1  out_data/sel hold a valid word.
- out_data  output  W  registered selected data.
- sel  output  2  registered index of the channel that produced out_data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, sel=0.
  - Round-robin pointer last=3, so channel 0 has first priority after reset.
  - in_ready=0 while rst_n=0.
- Load condition: load_en = !out_valid || out_ready. It depends on output state only, never on in_valid, so there is no combinational path from in_valid to out_ready.
- Grant (combinational), when load_en=1 and in_valid!=0:
  - grant = first set bit of in_valid scanning (last+1), (last+2), (last+3), last, modulo 4.
  - in_ready = onehot(grant).
  - Otherwise in_ready=0.
- Transfer on channel i: in_valid[i] && in_ready[i]. At the clock edge:
  - out_data <= in_data_i
  - sel <= i
  - out_valid <= 1
  - last <= i
- Latency: an input accepted in cycle t appears on out_data/sel with out_valid=1 in cycle t+1.
- Throughput: one word per cycle when out_ready stays high.
- Output drain: out_valid && out_ready with no new grant -> out_valid <= 0. out_data and sel hold their last values; they are don't-care for checking.
- Stall: out_valid && !out_ready -> out_data, sel, out_valid and last hold; in_ready=0.
- Simultaneous events: output handshake and a new grant in the same cycle -> the new word replaces the old one with no bubble.
- Fairness: a channel held valid waits at most 3 transfers before its grant.
- Wrap-around: last=3 -> scan starts at 0.
- Single requester: that requester is granted regardless of last.
- Input data is sampled only on the transfer edge. An input may change its data or drop valid while not granted.
- Reset mid-operation: the registered word is discarded with no output handshake, and the pointer returns to last=3.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Grant is fixed priority, lowest index wins (channel 0 highest).
  - `last` is not implemented.
  - The fairness guarantee is waived.
- Undefined: round-robin as above.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package rr_mux_pkg:
  - NCH=4
  - typedef chan_idx_t = logic [1:0]
  - typedef chan_mask_t = logic [3:0]
  - function rr_pick(chan_mask_t req, chan_idx_t last) returning chan_idx_t and a valid bit.
- One natural sub-module: rr_pick_4, the combinational grant logic.
  - Inputs: request mask, last.
  - Outputs: index, any.
  - Its fixed-priority variant is selected by the macro.
- The data select inside the top reuses a 4:1 mux on the granted index.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, sel=0 and in_ready=0 immediately, no clock needed. After release, in_valid=4'b1111 -> grant order 0,1,2,3,0.
- Single channel: in_valid=4'b0100, in_data2=4'hA, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=4'hA, sel=2.
- Backpressure: out_ready=0 with an output word present and in_valid=4'b0011 -> in_ready=0, output stable for 5 cycles. Raise out_ready -> the pending word is consumed and a new grant issues the same cycle, with no bubble.
- Round-robin wrap: last=3, in_valid=4'b1001 -> grant 0. Then grant 3. Then grant 0.
- Fairness: 1000 random cycles with random in_valid and out_ready -> no held-valid channel waits more than 3 transfers. A scoreboard matches every (sel, out_data) against the accepted input. (Skipped when RR_MUX_FIXED_PRIO_EN is defined.)
- Fixed priority (RR_MUX_FIXED_PRIO_EN defined): in_valid=4'b1110 held, out_ready=1 -> sel stays 1 for every output.
